cosine2x_inverse_search: RTL and testbench

//  Inverse of the COSINE2X degree look-up table: takes a 64-bit IEEE-754 double and returns the table degree (0..90) whose
//  `COSINE2X_DEG_nn magnitude is nearest to it, plus the sign class. Sits beside the cosine2x LUT in the trig FPU datapath
//  and is used for result checking and for recovering (angle, quadrant class) from a looked-up value.

---
 rtl/cosine2x_inverse_search_if.sv | 24 ++
 rtl/cosine2x_inverse_search.sv | 266 ++++++++++++++++++++++++++
 tb/tb_cosine2x_inverse_search.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/cosine2x_inverse_search_if.sv
// Request/result bundle for the cosine2x inverse search: double in, nearest degree,
// sign class and status flags out.
interface cosine2x_inverse_search_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      start;
    logic [2*DATA_WIDTH-1:0]   value_in;
    logic                      busy;
    logic                      done;
    logic [DATA_WIDTH-1:0]     angle_out;
    logic                      sign_neg;
    logic                      exact;
    logic                      error;

    modport master (
        output start, value_in,
        input  busy, done, angle_out, sign_neg, exact, error
    );

    modport slave (
        input  start, value_in,
        output busy, done, angle_out, sign_neg, exact, error
    );
endinterface

// File: rtl/cosine2x_inverse_search.sv
// Inverse of the cosine2x degree LUT: linear scan, one entry per cycle, for the entry whose
// magnitude is nearest the input double, with early exit on an exact bit-for-bit match.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

// Standalone copies of the LUT entries (cos of the degree, positive double, sign bit dropped).
`ifndef COSINE2X_DEG_00
`define COSINE2X_DEG_00 63'h3FF0000000000000
`define COSINE2X_DEG_01 63'h3FEFFEC000000000
`define COSINE2X_DEG_02 63'h3FEFFB0000000000
`define COSINE2X_DEG_03 63'h3FEFF4C000000000
`define COSINE2X_DEG_04 63'h3FEFEC0000000000
`define COSINE2X_DEG_05 63'h3FEFE0D000000000
`define COSINE2X_DEG_06 63'h3FEFD32000000000
`define COSINE2X_DEG_07 63'h3FEFC30000000000
`define COSINE2X_DEG_08 63'h3FEFB05000000000
`define COSINE2X_DEG_09 63'h3FEF9B3000000000
`define COSINE2X_DEG_10 63'h3FEF839000000000
`define COSINE2X_DEG_11 63'h3FEF698000000000
`define COSINE2X_DEG_12 63'h3FEF4D0000000000
`define COSINE2X_DEG_13 63'h3FEF2E1000000000
`define COSINE2X_DEG_14 63'h3FEF0CB000000000
`define COSINE2X_DEG_15 63'h3FEEE8E000000000
`define COSINE2X_DEG_16 63'h3FEEC2A000000000
`define COSINE2X_DEG_17 63'h3FEE9A0000000000
`define COSINE2X_DEG_18 63'h3FEE6F1000000000
`define COSINE2X_DEG_19 63'h3FEE41B000000000
`define COSINE2X_DEG_20 63'h3FEE11F000000000
`define COSINE2X_DEG_21 63'h3FEDDFE000000000
`define COSINE2X_DEG_22 63'h3FEDAB7000000000
`define COSINE2X_DEG_23 63'h3FED74C000000000
`define COSINE2X_DEG_24 63'h3FED3BD000000000
`define COSINE2X_DEG_25 63'h3FED008000000000
`define COSINE2X_DEG_26 63'h3FECC2E000000000
`define COSINE2X_DEG_27 63'h3FEC832000000000
`define COSINE2X_DEG_28 63'h3FEC412000000000
`define COSINE2X_DEG_29 63'h3FEBFCE000000000
`define COSINE2X_DEG_30 63'h3FEBB67AE8584CAA
`define COSINE2X_DEG_31 63'h3FEB6DF000000000
`define COSINE2X_DEG_32 63'h3FEB234000000000
`define COSINE2X_DEG_33 63'h3FEAD66000000000
`define COSINE2X_DEG_34 63'h3FEA878000000000
`define COSINE2X_DEG_35 63'h3FEA368000000000
`define COSINE2X_DEG_36 63'h3FE9E38000000000
`define COSINE2X_DEG_37 63'h3FE98E7000000000
`define COSINE2X_DEG_38 63'h3FE9376000000000
`define COSINE2X_DEG_39 63'h3FE8DE7000000000
`define COSINE2X_DEG_40 63'h3FE8836000000000
`define COSINE2X_DEG_41 63'h3FE8269000000000
`define COSINE2X_DEG_42 63'h3FE7C7D000000000
`define COSINE2X_DEG_43 63'h3FE7673000000000
`define COSINE2X_DEG_44 63'h3FE704D000000000
`define COSINE2X_DEG_45 63'h3FE6A09E667F3BCD
`define COSINE2X_DEG_46 63'h3FE63AA000000000
`define COSINE2X_DEG_47 63'h3FE5D2F000000000
`define COSINE2X_DEG_48 63'h3FE5698000000000
`define COSINE2X_DEG_49 63'h3FE4FE7000000000
`define COSINE2X_DEG_50 63'h3FE491C000000000
`define COSINE2X_DEG_51 63'h3FE4236000000000
`define COSINE2X_DEG_52 63'h3FE3B38000000000
`define COSINE2X_DEG_53 63'h3FE3422000000000
`define COSINE2X_DEG_54 63'h3FE2CF3000000000
`define COSINE2X_DEG_55 63'h3FE25AC000000000
`define COSINE2X_DEG_56 63'h3FE1E4E000000000
`define COSINE2X_DEG_57 63'h3FE16DB000000000
`define COSINE2X_DEG_58 63'h3FE0F52000000000
`define COSINE2X_DEG_59 63'h3FE07B3000000000
`define COSINE2X_DEG_60 63'h3FE0000000000000
`define COSINE2X_DEG_61 63'h3FDF072000000000
`define COSINE2X_DEG_62 63'h3FDE0BD000000000
`define COSINE2X_DEG_63 63'h3FDD0E3000000000
`define COSINE2X_DEG_64 63'h3FDC0E4000000000
`define COSINE2X_DEG_65 63'h3FDB0C3000000000
`define COSINE2X_DEG_66 63'h3FDA080000000000
`define COSINE2X_DEG_67 63'h3FD901C000000000
`define COSINE2X_DEG_68 63'h3FD7F9A000000000
`define COSINE2X_DEG_69 63'h3FD6EF9000000000
`define COSINE2X_DEG_70 63'h3FD5E3A000000000
`define COSINE2X_DEG_71 63'h3FD4D62000000000
`define COSINE2X_DEG_72 63'h3FD3C70000000000
`define COSINE2X_DEG_73 63'h3FD2B63000000000
`define COSINE2X_DEG_74 63'h3FD1A41000000000
`define COSINE2X_DEG_75 63'h3FD0908000000000
`define COSINE2X_DEG_76 63'h3FCEF74000000000
`define COSINE2X_DEG_77 63'h3FCCCB3000000000
`define COSINE2X_DEG_78 63'h3FCA9CD000000000
`define COSINE2X_DEG_79 63'h3FC86C7000000000
`define COSINE2X_DEG_80 63'h3FC63A3000000000
`define COSINE2X_DEG_81 63'h3FC405E000000000
`define COSINE2X_DEG_82 63'h3FC1D05000000000
`define COSINE2X_DEG_83 63'h3FBF32E000000000
`define COSINE2X_DEG_84 63'h3FBAC28000000000
`define COSINE2X_DEG_85 63'h3FB6502000000000
`define COSINE2X_DEG_86 63'h3FB1DBD000000000
`define COSINE2X_DEG_87 63'h3FAACC5000000000
`define COSINE2X_DEG_88 63'h3FA1DE7000000000
`define COSINE2X_DEG_89 63'h3F91DE7000000000
`define COSINE2X_DEG_90 63'h3C91A62633145C07
`endif

module cosine2x_inverse_search #(
    parameter int NUM_ENTRIES = 91,
    parameter int IDX_W       = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    cosine2x_inverse_search_if.slave  bus
);
    localparam int DW = `DATA_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [62:0]      ONE_MAG  = 63'h3FF0000000000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_r, next_state_s;
    logic [IDX_W-1:0] idx_r, best_idx_r;
    logic [62:0]     mag_r, best_diff_r, entry_s, diff_s;
    logic            bad_s, busy_r, done_r, sign_neg_r, exact_r, error_r;
    logic [DW-1:0]   angle_r;

    function automatic logic [62:0] table_entry(input logic [6:0] i);
        case (i)
            7'd0:  table_entry = `COSINE2X_DEG_00;  7'd1:  table_entry = `COSINE2X_DEG_01;
            7'd2:  table_entry = `COSINE2X_DEG_02;  7'd3:  table_entry = `COSINE2X_DEG_03;
            7'd4:  table_entry = `COSINE2X_DEG_04;  7'd5:  table_entry = `COSINE2X_DEG_05;
            7'd6:  table_entry = `COSINE2X_DEG_06;  7'd7:  table_entry = `COSINE2X_DEG_07;
            7'd8:  table_entry = `COSINE2X_DEG_08;  7'd9:  table_entry = `COSINE2X_DEG_09;
            7'd10: table_entry = `COSINE2X_DEG_10;  7'd11: table_entry = `COSINE2X_DEG_11;
            7'd12: table_entry = `COSINE2X_DEG_12;  7'd13: table_entry = `COSINE2X_DEG_13;
            7'd14: table_entry = `COSINE2X_DEG_14;  7'd15: table_entry = `COSINE2X_DEG_15;
            7'd16: table_entry = `COSINE2X_DEG_16;  7'd17: table_entry = `COSINE2X_DEG_17;
            7'd18: table_entry = `COSINE2X_DEG_18;  7'd19: table_entry = `COSINE2X_DEG_19;
            7'd20: table_entry = `COSINE2X_DEG_20;  7'd21: table_entry = `COSINE2X_DEG_21;
            7'd22: table_entry = `COSINE2X_DEG_22;  7'd23: table_entry = `COSINE2X_DEG_23;
            7'd24: table_entry = `COSINE2X_DEG_24;  7'd25: table_entry = `COSINE2X_DEG_25;
            7'd26: table_entry = `COSINE2X_DEG_26;  7'd27: table_entry = `COSINE2X_DEG_27;
            7'd28: table_entry = `COSINE2X_DEG_28;  7'd29: table_entry = `COSINE2X_DEG_29;
            7'd30: table_entry = `COSINE2X_DEG_30;  7'd31: table_entry = `COSINE2X_DEG_31;
            7'd32: table_entry = `COSINE2X_DEG_32;  7'd33: table_entry = `COSINE2X_DEG_33;
            7'd34: table_entry = `COSINE2X_DEG_34;  7'd35: table_entry = `COSINE2X_DEG_35;
            7'd36: table_entry = `COSINE2X_DEG_36;  7'd37: table_entry = `COSINE2X_DEG_37;
            7'd38: table_entry = `COSINE2X_DEG_38;  7'd39: table_entry = `COSINE2X_DEG_39;
            7'd40: table_entry = `COSINE2X_DEG_40;  7'd41: table_entry = `COSINE2X_DEG_41;
            7'd42: table_entry = `COSINE2X_DEG_42;  7'd43: table_entry = `COSINE2X_DEG_43;
            7'd44: table_entry = `COSINE2X_DEG_44;  7'd45: table_entry = `COSINE2X_DEG_45;
            7'd46: table_entry = `COSINE2X_DEG_46;  7'd47: table_entry = `COSINE2X_DEG_47;
            7'd48: table_entry = `COSINE2X_DEG_48;  7'd49: table_entry = `COSINE2X_DEG_49;
            7'd50: table_entry = `COSINE2X_DEG_50;  7'd51: table_entry = `COSINE2X_DEG_51;
            7'd52: table_entry = `COSINE2X_DEG_52;  7'd53: table_entry = `COSINE2X_DEG_53;
            7'd54: table_entry = `COSINE2X_DEG_54;  7'd55: table_entry = `COSINE2X_DEG_55;
            7'd56: table_entry = `COSINE2X_DEG_56;  7'd57: table_entry = `COSINE2X_DEG_57;
            7'd58: table_entry = `COSINE2X_DEG_58;  7'd59: table_entry = `COSINE2X_DEG_59;
            7'd60: table_entry = `COSINE2X_DEG_60;  7'd61: table_entry = `COSINE2X_DEG_61;
            7'd62: table_entry = `COSINE2X_DEG_62;  7'd63: table_entry = `COSINE2X_DEG_63;
            7'd64: table_entry = `COSINE2X_DEG_64;  7'd65: table_entry = `COSINE2X_DEG_65;
            7'd66: table_entry = `COSINE2X_DEG_66;  7'd67: table_entry = `COSINE2X_DEG_67;
            7'd68: table_entry = `COSINE2X_DEG_68;  7'd69: table_entry = `COSINE2X_DEG_69;
            7'd70: table_entry = `COSINE2X_DEG_70;  7'd71: table_entry = `COSINE2X_DEG_71;
            7'd72: table_entry = `COSINE2X_DEG_72;  7'd73: table_entry = `COSINE2X_DEG_73;
            7'd74: table_entry = `COSINE2X_DEG_74;  7'd75: table_entry = `COSINE2X_DEG_75;
            7'd76: table_entry = `COSINE2X_DEG_76;  7'd77: table_entry = `COSINE2X_DEG_77;
            7'd78: table_entry = `COSINE2X_DEG_78;  7'd79: table_entry = `COSINE2X_DEG_79;
            7'd80: table_entry = `COSINE2X_DEG_80;  7'd81: table_entry = `COSINE2X_DEG_81;
            7'd82: table_entry = `COSINE2X_DEG_82;  7'd83: table_entry = `COSINE2X_DEG_83;
            7'd84: table_entry = `COSINE2X_DEG_84;  7'd85: table_entry = `COSINE2X_DEG_85;
            7'd86: table_entry = `COSINE2X_DEG_86;  7'd87: table_entry = `COSINE2X_DEG_87;
            7'd88: table_entry = `COSINE2X_DEG_88;  7'd89: table_entry = `COSINE2X_DEG_89;
            7'd90: table_entry = `COSINE2X_DEG_90;
            default: table_entry = 63'h7FFFFFFFFFFFFFFF;
        endcase
    endfunction

    function automatic logic [62:0] abs_diff(input logic [62:0] a, input logic [62:0] b);
        if (a >= b) abs_diff = a - b;
        else        abs_diff = b - a;
    endfunction

    assign entry_s = table_entry(7'(idx_r));
    assign diff_s  = abs_diff(mag_r, entry_s);
    // NaN/Inf carry exponent 7FF; anything above 1.0 cannot be a cosine value.
    assign bad_s   = (mag_r[62:52] == 11'h7FF) || (mag_r > ONE_MAG);

    // Next-state selection for the IDLE/CHECK/SCAN/DONE sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:  if (bus.start) next_state_s = CHECK; else next_state_s = IDLE;
            CHECK: if (bad_s) next_state_s = DONE; else next_state_s = SCAN;
            SCAN:  if ((diff_s == 63'd0) || (idx_r == LAST_IDX)) next_state_s = DONE;
                   else next_state_s = SCAN;
            DONE:  next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register, scan datapath and registered result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            best_idx_r  <= '0;
            best_diff_r <= '1;
            mag_r       <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            sign_neg_r  <= 1'b0;
            exact_r     <= 1'b0;
            error_r     <= 1'b0;
            angle_r     <= '0;
        end else begin
            state_r <= next_state_s;
            done_r  <= (next_state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        mag_r      <= bus.value_in[62:0];
                        sign_neg_r <= bus.value_in[63];
                        exact_r    <= 1'b0;
                        error_r    <= 1'b0;
                        angle_r    <= '0;
                        busy_r     <= 1'b1;
                    end
                end
                CHECK: begin
                    if (bad_s) begin
                        error_r <= 1'b1;
                    end else begin
                        idx_r       <= '0;
                        best_diff_r <= '1;
                        best_idx_r  <= '0;
                    end
                end
                SCAN: begin
                    // Strict compare keeps the lowest index on ties.
                    if (diff_s < best_diff_r) begin
                        best_diff_r <= diff_s;
                        best_idx_r  <= idx_r;
                    end
                    if (diff_s == 63'd0) begin
                        exact_r <= 1'b1;
                        angle_r <= DW'(idx_r);
                    end else if (idx_r == LAST_IDX) begin
                        angle_r <= (diff_s < best_diff_r) ? DW'(idx_r) : DW'(best_idx_r);
                    end else begin
                        idx_r <= idx_r + IDX_W'(32'd1);
                    end
                end
                DONE: busy_r <= 1'b0;
                default: busy_r <= 1'b0;
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.angle_out = angle_r;
    assign bus.sign_neg  = sign_neg_r;
    assign bus.exact     = exact_r;
    assign bus.error     = error_r;
endmodule

// File: tb/tb_cosine2x_inverse_search.sv
// Randomised self-checking bench for cosine2x_inverse_search against a nearest-entry reference model.
module tb_cosine2x_inverse_search;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [62:0] tbl [0:90];

    always #5 clk = ~clk;

    cosine2x_inverse_search_if bus ();

    cosine2x_inverse_search dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference: error screen, then first entry at minimum absolute distance.
    function automatic void model(input logic [63:0] v, output int angle, output bit ex,
                                  output bit er, output int lat);
        logic [62:0] mag, d, best_d;
        mag   = v[62:0];
        angle = 0; ex = 1'b0; er = 1'b0;
        if (mag[62:52] == 11'h7FF || mag > 63'h3FF0000000000000) begin
            er = 1'b1; lat = 2;
            return;
        end
        best_d = '1;
        for (int k = 0; k <= 90; k++) begin
            d = (mag > tbl[k]) ? mag - tbl[k] : tbl[k] - mag;
            if (d == 63'd0) begin
                angle = k; ex = 1'b1; lat = k + 3;
                return;
            end
            if (d < best_d) begin
                best_d = d; angle = k;
            end
        end
        lat = 93;
    endfunction

    task automatic run_op(input logic [63:0] v, input bit pester, input string tag);
        int angle, lat, got;
        bit ex, er;
        model(v, angle, ex, er, lat);
        got = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.value_in = v;
        @(posedge clk);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (pester) begin
                bus.start    = 1'($urandom_range(0, 1));
                bus.value_in = {$urandom, $urandom};
            end else begin
                bus.start = 1'b0;
            end
            if (c == 1) check_val({tag, ".busy"}, 64'(bus.busy), 64'd1);
            if (bus.done) begin
                got = c;
                break;
            end
        end
        check_val({tag, ".lat"}, 64'(got), 64'(lat));
        check_val({tag, ".angle"}, 64'(bus.angle_out), 64'(angle));
        check_val({tag, ".exact"}, 64'(bus.exact), 64'(ex));
        check_val({tag, ".error"}, 64'(bus.error), 64'(er));
        check_val({tag, ".sign"}, 64'(bus.sign_neg), 64'(v[63]));
        // A start raised during the DONE cycle must not be taken.
        if (pester) bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_val({tag, ".done1"}, 64'(bus.done), 64'd0);
        check_val({tag, ".idle"}, 64'(bus.busy), 64'd0);
        check_val({tag, ".hold"}, 64'(bus.angle_out), 64'(angle));
    endtask

    initial begin
        logic [63:0] v;
        logic [62:0] mag, r63;
        int   k;
        bit   seen_done;

        tbl[0]  = `COSINE2X_DEG_00; tbl[1]  = `COSINE2X_DEG_01; tbl[2]  = `COSINE2X_DEG_02; tbl[3]  = `COSINE2X_DEG_03;
        tbl[4]  = `COSINE2X_DEG_04; tbl[5]  = `COSINE2X_DEG_05; tbl[6]  = `COSINE2X_DEG_06; tbl[7]  = `COSINE2X_DEG_07;
        tbl[8]  = `COSINE2X_DEG_08; tbl[9]  = `COSINE2X_DEG_09; tbl[10] = `COSINE2X_DEG_10; tbl[11] = `COSINE2X_DEG_11;
        tbl[12] = `COSINE2X_DEG_12; tbl[13] = `COSINE2X_DEG_13; tbl[14] = `COSINE2X_DEG_14; tbl[15] = `COSINE2X_DEG_15;
        tbl[16] = `COSINE2X_DEG_16; tbl[17] = `COSINE2X_DEG_17; tbl[18] = `COSINE2X_DEG_18; tbl[19] = `COSINE2X_DEG_19;
        tbl[20] = `COSINE2X_DEG_20; tbl[21] = `COSINE2X_DEG_21; tbl[22] = `COSINE2X_DEG_22; tbl[23] = `COSINE2X_DEG_23;
        tbl[24] = `COSINE2X_DEG_24; tbl[25] = `COSINE2X_DEG_25; tbl[26] = `COSINE2X_DEG_26; tbl[27] = `COSINE2X_DEG_27;
        tbl[28] = `COSINE2X_DEG_28; tbl[29] = `COSINE2X_DEG_29; tbl[30] = `COSINE2X_DEG_30; tbl[31] = `COSINE2X_DEG_31;
        tbl[32] = `COSINE2X_DEG_32; tbl[33] = `COSINE2X_DEG_33; tbl[34] = `COSINE2X_DEG_34; tbl[35] = `COSINE2X_DEG_35;
        tbl[36] = `COSINE2X_DEG_36; tbl[37] = `COSINE2X_DEG_37; tbl[38] = `COSINE2X_DEG_38; tbl[39] = `COSINE2X_DEG_39;
        tbl[40] = `COSINE2X_DEG_40; tbl[41] = `COSINE2X_DEG_41; tbl[42] = `COSINE2X_DEG_42; tbl[43] = `COSINE2X_DEG_43;
        tbl[44] = `COSINE2X_DEG_44; tbl[45] = `COSINE2X_DEG_45; tbl[46] = `COSINE2X_DEG_46; tbl[47] = `COSINE2X_DEG_47;
        tbl[48] = `COSINE2X_DEG_48; tbl[49] = `COSINE2X_DEG_49; tbl[50] = `COSINE2X_DEG_50; tbl[51] = `COSINE2X_DEG_51;
        tbl[52] = `COSINE2X_DEG_52; tbl[53] = `COSINE2X_DEG_53; tbl[54] = `COSINE2X_DEG_54; tbl[55] = `COSINE2X_DEG_55;
        tbl[56] = `COSINE2X_DEG_56; tbl[57] = `COSINE2X_DEG_57; tbl[58] = `COSINE2X_DEG_58; tbl[59] = `COSINE2X_DEG_59;
        tbl[60] = `COSINE2X_DEG_60; tbl[61] = `COSINE2X_DEG_61; tbl[62] = `COSINE2X_DEG_62; tbl[63] = `COSINE2X_DEG_63;
        tbl[64] = `COSINE2X_DEG_64; tbl[65] = `COSINE2X_DEG_65; tbl[66] = `COSINE2X_DEG_66; tbl[67] = `COSINE2X_DEG_67;
        tbl[68] = `COSINE2X_DEG_68; tbl[69] = `COSINE2X_DEG_69; tbl[70] = `COSINE2X_DEG_70; tbl[71] = `COSINE2X_DEG_71;
        tbl[72] = `COSINE2X_DEG_72; tbl[73] = `COSINE2X_DEG_73; tbl[74] = `COSINE2X_DEG_74; tbl[75] = `COSINE2X_DEG_75;
        tbl[76] = `COSINE2X_DEG_76; tbl[77] = `COSINE2X_DEG_77; tbl[78] = `COSINE2X_DEG_78; tbl[79] = `COSINE2X_DEG_79;
        tbl[80] = `COSINE2X_DEG_80; tbl[81] = `COSINE2X_DEG_81; tbl[82] = `COSINE2X_DEG_82; tbl[83] = `COSINE2X_DEG_83;
        tbl[84] = `COSINE2X_DEG_84; tbl[85] = `COSINE2X_DEG_85; tbl[86] = `COSINE2X_DEG_86; tbl[87] = `COSINE2X_DEG_87;
        tbl[88] = `COSINE2X_DEG_88; tbl[89] = `COSINE2X_DEG_89; tbl[90] = `COSINE2X_DEG_90;

        reset = 1'b1;
        bus.start = 1'b0;
        bus.value_in = 64'd0;
        repeat (3) @(negedge clk);
        check_val("rst.busy", 64'(bus.busy), 64'd0);
        check_val("rst.done", 64'(bus.done), 64'd0);
        check_val("rst.angle", 64'(bus.angle_out), 64'd0);
        check_val("rst.flags", {61'd0, bus.sign_neg, bus.exact, bus.error}, 64'd0);
        reset = 1'b0;

        run_op({1'b0, tbl[0]}, 1'b0, "t1");
        run_op({1'b1, tbl[37]}, 1'b0, "t2");
        run_op(64'h7FF8000000000000, 1'b0, "t3.nan");
        run_op(64'h4000000000000000, 1'b0, "t3.two");
        run_op(64'hFFF0000000000000, 1'b0, "t3.ninf");
        run_op(64'h3FF0000000000001, 1'b0, "t3.above1");
        run_op(64'hBFF0000000000000, 1'b0, "neg1");
        run_op(64'h0000000000000000, 1'b0, "pzero");
        run_op(64'h8000000000000000, 1'b0, "nzero");
        run_op(64'h0000000000000001, 1'b0, "denorm");
        run_op({1'b0, tbl[20] + 63'd1}, 1'b0, "t4.lsb");
        run_op({1'b0, tbl[21] + (tbl[20] - tbl[21]) / 63'd2}, 1'b0, "t4.mid");
        run_op({1'b1, tbl[90]}, 1'b0, "last");

        // Reset during a long scan abandons it without a done pulse.
        @(negedge clk);
        bus.start = 1'b1;
        bus.value_in = {1'b1, tbl[60] - 63'd3};
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (29) @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("t5.busy", 64'(bus.busy), 64'd0);
        check_val("t5.angle", 64'(bus.angle_out), 64'd0);
        check_val("t5.flags", {60'd0, bus.done, bus.sign_neg, bus.exact, bus.error}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen_done = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (bus.done) seen_done = 1'b1;
        end
        check_val("t5.nodone", 64'(seen_done), 64'd0);
        run_op({1'b0, tbl[5]}, 1'b0, "t5.restart");

        run_op({1'b0, tbl[50] + 63'd5}, 1'b1, "t6");
        run_op({1'b1, tbl[12]}, 1'b1, "t6.exact");

        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 90);
            r63 = 63'({$urandom, $urandom});
            case ($urandom_range(0, 5))
                0: mag = tbl[k];
                1: mag = ($urandom_range(0, 1) == 0) ? tbl[k] + 63'($urandom_range(1, 1000))
                                                     : tbl[k] - 63'($urandom_range(1, 1000));
                2: mag = (k < 90) ? tbl[k + 1] + (tbl[k] - tbl[k + 1]) / 63'd2 : tbl[k];
                3: mag = r63 % 63'h3FF0000000000001;
                4: mag = r63;
                default: mag = {11'h3C0 + 11'($urandom_range(0, 63)), r63[51:0]};
            endcase
            v = {1'($urandom_range(0, 1)), mag};
            run_op(v, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
